// File: rtl/div_pkg.sv
// Shared types and helpers for divided-clock monitors.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2
    } mon_state_e;

    // Absolute difference without wrap: larger minus smaller.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/div_ratio_monitor_if.sv
// Stimulus/status bundle between a divider under test and its ratio monitor.
interface div_ratio_monitor_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ERR_W = 8
);
    logic             div_in;
    logic             err_clr;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic             timeout;

    modport master (
        output div_in, err_clr,
        input  period, high_time, meas_valid, locked, err, err_count, timeout
    );

    modport slave (
        input  div_in, err_clr,
        output period, high_time, meas_valid, locked, err, err_count, timeout
    );
endinterface

// File: rtl/edge_det.sv
// Registers the previous sample and flags rising/falling edges of a clk-synchronous signal.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise_c,
    output logic fall_c
);
    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;
    end

    assign rise_c = sig & ~prev_q;
    assign fall_c = ~sig & prev_q;
endmodule

// File: rtl/div_ratio_monitor.sv
// Measures period and high time of a divided clock, checks them against expected
// values within a tolerance, and reports lock, sticky error and timeout status.
module div_ratio_monitor
    import div_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXP_PERIOD = 9,
    parameter int unsigned EXP_HIGH   = 5,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    div_ratio_monitor_if.slave  mon
);
    localparam int unsigned      GR_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [GR_W-1:0]  GR_LOCK = GR_W'(LOCK_COUNT);

    logic rise_c;
    logic unused_fall_c;

    edge_det u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig    (mon.div_in),
        .rise_c (rise_c),
        .fall_c (unused_fall_c)
    );

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [GR_W-1:0]  good_run_q, good_run_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic             good_c;
    logic             bad_c;

    assign good_c = (abs_diff(32'(per_cnt_q), 32'(EXP_PERIOD)) <= 32'(TOL)) &&
                    (abs_diff(32'(hi_cnt_q),  32'(EXP_HIGH))   <= 32'(TOL));

    // Next-state, counters and status; bad events are applied last so they win over err_clr.
    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        good_run_d   = good_run_q;
        err_count_d  = err_count_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        err_d        = err_q;
        timeout_d    = 1'b0;
        bad_c        = 1'b0;

        if (mon.err_clr) begin
            err_d       = 1'b0;
            err_count_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d   = ARM;
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = CNT_W'(1);
                end
            end
            ARM, TRACK: begin
                if (rise_c) begin
                    state_d      = TRACK;
                    per_cnt_d    = CNT_W'(1);
                    hi_cnt_d     = CNT_W'(1);
                    period_d     = per_cnt_q;
                    high_time_d  = hi_cnt_q;
                    meas_valid_d = 1'b1;
                    if (good_c) begin
                        if (good_run_q != GR_LOCK) good_run_d = good_run_q + GR_W'(1);
                        if (good_run_d == GR_LOCK) locked_d = 1'b1;
                    end else begin
                        bad_c = 1'b1;
                    end
                end else if (per_cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    timeout_d = 1'b1;
                    bad_c     = 1'b1;
                end else begin
                    per_cnt_d = per_cnt_q + CNT_W'(1);
                    if (mon.div_in) hi_cnt_d = hi_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (bad_c) begin
            good_run_d = '0;
            locked_d   = 1'b0;
            err_d      = 1'b1;
            if (err_count_d != ERR_MAX) err_count_d = err_count_d + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            good_run_q   <= '0;
            err_count_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            good_run_q   <= good_run_d;
            err_count_q  <= err_count_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign mon.period     = period_q;
    assign mon.high_time  = high_time_q;
    assign mon.meas_valid = meas_valid_q;
    assign mon.locked     = locked_q;
    assign mon.err        = err_q;
    assign mon.err_count  = err_count_q;
    assign mon.timeout    = timeout_q;
endmodule

// File: tb/tb_div_ratio_monitor.sv
// Scoreboard bench for div_ratio_monitor: a time-based reference model predicts
// per-cycle status and measurement/timeout events; a monitor compares them.
module tb_div_ratio_monitor;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned ERR_W      = 8;
    localparam int          EXP_PERIOD = 9;
    localparam int          EXP_HIGH   = 5;
    localparam int          TOL        = 1;
    localparam int          LOCK_COUNT = 4;
    localparam int          TIMEOUT_GAP = 255;
    localparam int          ERR_SAT    = 255;

    logic clk;
    logic rst_n;

    div_ratio_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) mi ();

    div_ratio_monitor #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .EXP_HIGH(EXP_HIGH),
        .TOL(TOL), .LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (mi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit is_to;
        int per;
        int hi;
    } ev_t;

    typedef struct {
        int due;
        bit locked;
        bit err;
        int cnt;
        int per;
        int hi;
    } st_t;

    ev_t eq[$];
    st_t sq[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: time of last rise, high samples since it, and status.
    bit m_armed, m_prev, m_locked, m_err;
    int m_last_rise, m_hi, m_run, m_cnt, m_per, m_high;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_edge(input bit d, input bit clr, input bit rst);
        int  e;
        bit  rise;
        bit  bad;
        ev_t ev;
        st_t st;
        e = cyc + 1;
        bad = 1'b0;
        if (!rst) begin
            m_armed = 0; m_prev = 0; m_locked = 0; m_err = 0;
            m_last_rise = 0; m_hi = 0; m_run = 0; m_cnt = 0; m_per = 0; m_high = 0;
        end else begin
            rise = d && !m_prev;
            m_prev = d;
            if (clr) begin m_err = 0; m_cnt = 0; end
            if (m_armed) begin
                if (rise) begin
                    m_per  = e - m_last_rise;
                    m_high = m_hi;
                    if (absd(m_per, EXP_PERIOD) <= TOL && absd(m_high, EXP_HIGH) <= TOL) begin
                        if (m_run < LOCK_COUNT) m_run++;
                        if (m_run == LOCK_COUNT) m_locked = 1;
                    end else begin
                        bad = 1;
                    end
                    ev.due = e; ev.is_to = 0; ev.per = m_per; ev.hi = m_high;
                    eq.push_back(ev);
                end else if (e - m_last_rise == TIMEOUT_GAP) begin
                    m_armed = 0;
                    bad = 1;
                    ev.due = e; ev.is_to = 1; ev.per = 0; ev.hi = 0;
                    eq.push_back(ev);
                end else if (d) begin
                    m_hi++;
                end
            end
            if (rise) begin
                m_armed = 1; m_last_rise = e; m_hi = 1;
            end
            if (bad) begin
                m_run = 0; m_locked = 0; m_err = 1;
                if (m_cnt < ERR_SAT) m_cnt++;
            end
        end
        st.due = e; st.locked = m_locked; st.err = m_err; st.cnt = m_cnt;
        st.per = m_per; st.hi = m_high;
        sq.push_back(st);
    endtask

    // Monitor: per-cycle status plus measurement/timeout events.
    always @(negedge clk) begin
        st_t s;
        ev_t e;
        if (sq.size() > 0 && sq[0].due == cyc) begin
            s = sq.pop_front();
            checks++;
            if (mi.locked !== s.locked || mi.err !== s.err || mi.err_count !== ERR_W'(s.cnt) ||
                mi.period !== CNT_W'(s.per) || mi.high_time !== CNT_W'(s.hi)) begin
                errors++;
                $display("FAIL status cyc=%0d got lk=%b err=%b cnt=%0d per=%0d hi=%0d exp lk=%b err=%b cnt=%0d per=%0d hi=%0d",
                         cyc, mi.locked, mi.err, mi.err_count, mi.period, mi.high_time,
                         s.locked, s.err, s.cnt, s.per, s.hi);
            end
        end
        while (eq.size() > 0 && eq[0].due < cyc) begin
            e = eq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event cyc=%0d got none exp %s due=%0d", cyc,
                     e.is_to ? "timeout" : "meas_valid", e.due);
        end
        if (mi.meas_valid !== 1'b0 || mi.timeout !== 1'b0) begin
            checks++;
            if (eq.size() == 0 || eq[0].due != cyc) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got mv=%b to=%b exp none", cyc,
                         mi.meas_valid, mi.timeout);
            end else begin
                e = eq.pop_front();
                if (mi.meas_valid !== !e.is_to || mi.timeout !== e.is_to ||
                    (!e.is_to && (mi.period !== CNT_W'(e.per) || mi.high_time !== CNT_W'(e.hi)))) begin
                    errors++;
                    $display("FAIL event cyc=%0d got mv=%b to=%b per=%0d hi=%0d exp to=%b per=%0d hi=%0d",
                             cyc, mi.meas_valid, mi.timeout, mi.period, mi.high_time,
                             e.is_to, e.per, e.hi);
                end
            end
        end
    end

    task automatic step(input bit d, input bit clr, input bit r);
        mi.div_in  = d;
        mi.err_clr = clr;
        rst_n      = r;
        model_edge(d, clr, r);
        @(negedge clk);
    endtask

    task automatic wave(input int hi, input int lo, input bit clr_on_rise);
        for (int i = 0; i < hi; i++) step(1'b1, clr_on_rise && (i == 0), 1'b1);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        mi.div_in  = 1'b0;
        mi.err_clr = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);

        // Reset with div_in toggling.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Ideal div-by-9 until locked.
        for (int i = 0; i < 7; i++) wave(5, 4, 1'b0);

        // Div-by-12: every measurement bad.
        for (int i = 0; i < 5; i++) wave(6, 6, 1'b0);

        // Relock, then stall low until timeout, then recover.
        for (int i = 0; i < 6; i++) wave(5, 4, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) wave(5, 4, 1'b0);

        // Lock, then reset mid-period.
        for (int i = 0; i < 5; i++) wave(5, 4, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) wave(5, 4, 1'b0);

        // err_clr coincident with a bad measurement at err_count=3, then alone.
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) wave(6, 6, 1'b0);
        wave(6, 6, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

        // Stuck high long enough to time out.
        for (int i = 0; i < 270; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Randomized waveforms with sporadic err_clr.
        for (int i = 0; i < 60; i++) begin
            int hi;
            int lo;
            hi = $urandom_range(7, 3);
            lo = $urandom_range(6, 2);
            for (int k = 0; k < hi; k++) step(1'b1, $urandom_range(15, 0) == 0, 1'b1);
            for (int k = 0; k < lo; k++) step(1'b0, $urandom_range(15, 0) == 0, 1'b1);
        end

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (eq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL drain got ev=%0d st=%0d pending exp 0", eq.size(), sq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
